// File: rtl/dsm_pkg.sv
// Shared types and width helpers for the delta-sigma interpolator.
package dsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Difference of two samples needs one extra bit to hold the full signed span.
  function automatic int diffWidth(input int dataWidth);
    return dataWidth + 1;
  endfunction

  function automatic int prodWidth(input int dataWidth, input int osrLog2);
    return dataWidth + 1 + osrLog2;
  endfunction

endpackage

// File: rtl/dsm_tick_gen.sv
// Free-running divider: o_tick is high for one i_clk cycle out of every CLK_DIV.
module dsm_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = o_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dsm_interp.sv
// Sample interpolator feeding a delta-sigma modulator; zero-order hold by default,
// linear ramp between samples when DSM_INTERP_LINEAR_EN is defined.
module dsm_interp
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OSR_LOG2   = 6,
  parameter int CLK_DIV    = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic                         o_en,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_underflow
);

  state_e                       state_q, state_d;
  logic [OSR_LOG2-1:0]          k_q, k_d;
  logic signed [DATA_WIDTH-1:0] base_q, base_d, target_q, target_d;
  logic signed [DATA_WIDTH-1:0] buf_q, buf_d, data_q, data_d;
  logic                         ready_q, ready_d, en_q, uf_q, uf_d;
  logic                         tick, consume, boundaryEmpty;
  logic signed [DATA_WIDTH-1:0] baseNow, targetNow, interp;

  dsm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  // Segment endpoints in effect for this tick; a segment start swaps in the buffered sample.
  always_comb begin
    consume       = 1'b0;
    boundaryEmpty = 1'b0;
    baseNow       = base_q;
    targetNow     = target_q;
    if (tick) begin
      if (state_q == IDLE) begin
        if (!ready_q) begin
          consume   = 1'b1;
          baseNow   = '0;
          targetNow = buf_q;
        end
      end else if (k_q == '0) begin
        baseNow = target_q;
        if (!ready_q) begin
          consume   = 1'b1;
          targetNow = buf_q;
        end else begin
          boundaryEmpty = 1'b1;
        end
      end
    end
  end

`ifdef DSM_INTERP_LINEAR_EN
  localparam int DIFF_W = diffWidth(DATA_WIDTH);
  localparam int PROD_W = prodWidth(DATA_WIDTH, OSR_LOG2);

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    diff   = DIFF_W'(targetNow) - DIFF_W'(baseNow);
    prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, k_q}));
    interp = DATA_WIDTH'(PROD_W'(baseNow) + (prod >>> OSR_LOG2));
  end
`else
  always_comb begin
    interp = targetNow;
  end
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    target_d = target_q;
    buf_d    = buf_q;
    ready_d  = ready_q;
    data_d   = data_q;
    uf_d     = 1'b0;
    if (tick) begin
      if (state_q == RUN || consume) begin
        state_d  = RUN;
        k_d      = k_q + OSR_LOG2'(1);
        base_d   = baseNow;
        target_d = targetNow;
        data_d   = interp;
        uf_d     = boundaryEmpty;
      end else begin
        data_d = '0;
      end
    end
    // Accept and consume never coincide: accepting needs an empty buffer, consuming a full one.
    if (i_valid && ready_q) begin
      buf_d   = i_data;
      ready_d = 1'b0;
    end else if (consume) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      base_q   <= '0;
      target_q <= '0;
      buf_q    <= '0;
      ready_q  <= 1'b1;
      data_q   <= '0;
      en_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      target_q <= target_d;
      buf_q    <= buf_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      en_q     <= tick;
      uf_q     <= uf_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_en        = en_q;
  assign o_data      = data_q;
  assign o_underflow = uf_q;

endmodule

// File: doc/dsm_interp.md
DSM_INTERP -- requirements
Module: dsm_interp

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, meaning sample width (signed two's complement).
REQ-002 SHALL provide parameter OSR_LOG2, default 6, meaning log2 of the interpolation ratio; OSR = 2^OSR_LOG2, legal range 1..8.
REQ-003 SHALL provide parameter CLK_DIV, default 1, meaning i_clk cycles per output tick, legal 1..255.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port i_valid, input, 1, meaning an input sample is offered.
REQ-007 SHALL have port i_data, input, DATA_WIDTH signed, meaning the input sample.
REQ-008 SHALL have port o_ready, output, 1, meaning the block accepts i_data this cycle.
REQ-009 SHALL have port o_en, output, 1, meaning a one-cycle tick qualifying o_data; it drives the downstream modulator enable.
REQ-010 SHALL have port o_data, output, DATA_WIDTH signed, meaning the interpolated sample for the modulator.
REQ-011 SHALL have port o_underflow, output, 1, meaning a one-cycle pulse at a segment boundary with no sample buffered.

Function
REQ-012 SHALL accept a sample on any rising edge with i_valid=1 and o_ready=1 into a one-entry buffer.
REQ-013 SHALL drive o_ready = not buffer_full, directly from a register; a consumption frees the buffer, and o_ready rises on the following cycle, never combinationally in the consuming cycle.
REQ-014 SHALL run a tick divider continuously out of reset, asserting o_en for one cycle every CLK_DIV cycles (every cycle when CLK_DIV=1), with the first o_en CLK_DIV cycles after reset release.
REQ-015 SHALL implement states IDLE and RUN; IDLE holds o_data=0; IDLE->RUN on a tick with the buffer full; RUN->IDLE only via reset.
REQ-016 SHALL in RUN advance a phase counter k from 0 to OSR-1 on each tick, wrapping to 0; a segment starts at k=0.
REQ-017 SHALL at each segment start set base to the previous target (0 on the IDLE->RUN segment) and set target to the buffered sample, consuming it; if the buffer is empty, target SHALL equal base and o_underflow SHALL pulse.
REQ-018 SHALL on each RUN tick output o_data = base + ((target - base) * k >>> OSR_LOG2), using a DATA_WIDTH+1 bit difference, a DATA_WIDTH+1+OSR_LOG2 bit product and an arithmetic (floor) shift; the result never exceeds the DATA_WIDTH range.
REQ-019 SHALL register o_data and o_en on the same edge; o_data holds between ticks.
REQ-020 SHALL apply a sample accepted in the same cycle as a segment boundary tick to the next boundary, not the current one.

Reset
REQ-021 SHALL on i_rst (including mid-segment) immediately clear state to IDLE, k=0, base=target=0, buffer empty, divider=0, o_data=0, o_en=0, o_underflow=0, o_ready=1.

Configuration
REQ-022 SHALL, with macro DSM_INTERP_LINEAR_EN defined, behave as REQ-018 (linear ramp).
REQ-023 SHALL, without DSM_INTERP_LINEAR_EN, output o_data = target for every tick of the segment (zero-order hold); the multiplier SHALL be omitted, and all handshake and underflow behaviour SHALL be unchanged.

Structure
REQ-024 SHALL place the state enum (IDLE, RUN) and width helper constants (difference width, product width) in shared package dsm_pkg.
REQ-025 SHALL instantiate the tick divider as sub-module dsm_tick_gen (parameter CLK_DIV; ports i_clk, i_rst, o_tick).

Verification (DATA_WIDTH=16, OSR_LOG2=2, CLK_DIV=2, linear unless noted)
REQ-026 Reset released, no input -> o_data=0, o_ready=1, o_underflow=0, o_en high one cycle in every 2.
REQ-027 Stream 1000, 2000, 2000 back-to-back -> o_data on ticks 0,250,500,750,1000,1250,1500,1750,2000.
REQ-028 Stream 1000, -1000 -> the second segment outputs 1000,500,0,-500.
REQ-029 Stream 32767, -32768 -> the second segment outputs 32767,16383,-1,-16385, with no overflow.
REQ-030 Send 1000 only, then starve -> o_underflow pulses at each later boundary and o_data holds 1000; i_rst asserted mid-segment -> all outputs reset within the same cycle.
REQ-031 Macro undefined, send 1000 then 3000 -> 1000 x4 then 3000 x4; o_ready stays low for exactly the cycles the buffer is full.
